// File: rtl/rv32a_amo_mem.sv
// Memory-side RV32A responder: word RAM executing loads, stores, LR/SC and AMOs
// one request at a time through an IDLE/READ/EXEC/RESP sequence.
module rv32a_amo_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iREQ_VALID,
  output logic        oREQ_READY,
  input  logic        iREQ_AMO,
  input  logic        iREQ_WE,
  input  logic [4:0]  iREQ_FUNC5,
  input  logic [31:0] iREQ_ADDR,
  input  logic [31:0] iREQ_WDATA,
  output logic        oRSP_VALID,
  input  logic        iRSP_READY,
  output logic [31:0] oRSP_RDATA,
  output logic        oRSP_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_RESP} state_e;

  localparam logic [4:0] F_ADD  = 5'h00;
  localparam logic [4:0] F_SWAP = 5'h01;
  localparam logic [4:0] F_LR   = 5'h02;
  localparam logic [4:0] F_SC   = 5'h03;
  localparam logic [4:0] F_XOR  = 5'h04;
  localparam logic [4:0] F_OR   = 5'h08;
  localparam logic [4:0] F_AND  = 5'h0C;
  localparam logic [4:0] F_MIN  = 5'h10;
  localparam logic [4:0] F_MAX  = 5'h14;
  localparam logic [4:0] F_MINU = 5'h18;
  localparam logic [4:0] F_MAXU = 5'h1C;

  state_e          state_q, state_d;
  logic            amo_q, amo_d;
  logic            we_q, we_d;
  logic [4:0]      func5_q, func5_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            mis_q, mis_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            res_valid_q, res_valid_d;
  logic [AW-1:0]   res_idx_q, res_idx_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     old_q;
  logic            mem_we;

  logic            ex_wr;
  logic [31:0]     ex_new;
  logic [31:0]     ex_rdata;
  logic            ex_err;
  logic            ex_res_valid;
  logic [AW-1:0]   ex_res_idx;
  logic            ex_legal;

  // Address bits above the RAM window are deliberately ignored (addresses wrap).
  logic            unused_addr;
  assign unused_addr = ^iREQ_ADDR[31:AW+2];

  // Result of the latched request given the word read during READ.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    ex_wr        = 1'b0;
    ex_new       = wdata_q;
    ex_rdata     = old_q;
    ex_err       = 1'b0;
    ex_res_valid = res_valid_q;
    ex_res_idx   = res_idx_q;
    ex_legal     = 1'b1;
    if (!amo_q) begin
      if (we_q) begin
        ex_wr    = 1'b1;
        ex_rdata = 32'd0;
      end
    end else begin
      case (func5_q)
        F_ADD:  begin ex_wr = 1'b1; ex_new = old_q + wdata_q; end
        F_SWAP: ex_wr = 1'b1;
        F_XOR:  begin ex_wr = 1'b1; ex_new = old_q ^ wdata_q; end
        F_OR:   begin ex_wr = 1'b1; ex_new = old_q | wdata_q; end
        F_AND:  begin ex_wr = 1'b1; ex_new = old_q & wdata_q; end
        F_MIN:  begin ex_wr = 1'b1; ex_new = ($signed(old_q) < $signed(wdata_q)) ? old_q : wdata_q; end
        F_MAX:  begin ex_wr = 1'b1; ex_new = ($signed(old_q) > $signed(wdata_q)) ? old_q : wdata_q; end
        F_MINU: begin ex_wr = 1'b1; ex_new = (old_q < wdata_q) ? old_q : wdata_q; end
        F_MAXU: begin ex_wr = 1'b1; ex_new = (old_q > wdata_q) ? old_q : wdata_q; end
        F_LR: begin
          ex_res_valid = 1'b1;
          ex_res_idx   = idx_q;
        end
        F_SC: begin
          ex_res_valid = 1'b0;
          if (res_valid_q && (res_idx_q == idx_q)) begin
            ex_wr    = 1'b1;
            ex_rdata = 32'd0;
          end else begin
            ex_rdata = 32'd1;
          end
        end
        default: ex_legal = 1'b0;
      endcase
    end

    if (mis_q || !ex_legal) begin
      ex_wr        = 1'b0;
      ex_rdata     = 32'd0;
      ex_err       = 1'b1;
      ex_res_valid = res_valid_q;
      ex_res_idx   = res_idx_q;
    end else if (ex_wr && (idx_q == res_idx_q)) begin
      ex_res_valid = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    amo_d       = amo_q;
    we_d        = we_q;
    func5_d     = func5_q;
    idx_d       = idx_q;
    mis_d       = mis_q;
    wdata_d     = wdata_q;
    res_valid_d = res_valid_q;
    res_idx_d   = res_idx_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iREQ_VALID) begin
          amo_d   = iREQ_AMO;
          we_d    = iREQ_WE;
          func5_d = iREQ_FUNC5;
          idx_d   = iREQ_ADDR[AW+1:2];
          mis_d   = |iREQ_ADDR[1:0];
          wdata_d = iREQ_WDATA;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: begin
        mem_we      = ex_wr;
        res_valid_d = ex_res_valid;
        res_idx_d   = ex_res_idx;
        rsp_rdata_d = ex_rdata;
        rsp_err_d   = ex_err;
        state_d     = S_RESP;
      end
      S_RESP: if (iRSP_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (iRST) begin
      state_q     <= S_IDLE;
      amo_q       <= 1'b0;
      we_q        <= 1'b0;
      func5_q     <= 5'd0;
      idx_q       <= '0;
      mis_q       <= 1'b0;
      wdata_q     <= 32'd0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      amo_q       <= amo_d;
      we_q        <= we_d;
      func5_q     <= func5_d;
      idx_q       <= idx_d;
      mis_q       <= mis_d;
      wdata_q     <= wdata_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // NOTE: the RAM array and its read register are not reset, so they map onto plain block RAM.
  always_ff @(posedge iCLK) begin
    if (mem_we) mem[idx_q] <= ex_new;
    if (state_q == S_READ) old_q <= mem[idx_q];
  end

  assign oREQ_READY = (state_q == S_IDLE);
  assign oRSP_VALID = (state_q == S_RESP);
  assign oRSP_RDATA = rsp_rdata_q;
  assign oRSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_rv32a_amo_mem.sv
// Directed bench for rv32a_amo_mem: plain access, LR/SC, AMOs, errors,
// address aliasing, response back-pressure and reset during an operation.
module tb_rv32a_amo_mem;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iREQ_VALID;
  logic        oREQ_READY;
  logic        iREQ_AMO;
  logic        iREQ_WE;
  logic [4:0]  iREQ_FUNC5;
  logic [31:0] iREQ_ADDR;
  logic [31:0] iREQ_WDATA;
  logic        oRSP_VALID;
  logic        iRSP_READY;
  logic [31:0] oRSP_RDATA;
  logic        oRSP_ERR;

  int          total  = 0;
  int          passed = 0;
  int          fails  = 0;
  logic [31:0] r_data;
  logic        r_err;
  int          r_lat;

  rv32a_amo_mem #(.DEPTH(256), .AW(8)) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iREQ_VALID (iREQ_VALID),
    .oREQ_READY (oREQ_READY),
    .iREQ_AMO   (iREQ_AMO),
    .iREQ_WE    (iREQ_WE),
    .iREQ_FUNC5 (iREQ_FUNC5),
    .iREQ_ADDR  (iREQ_ADDR),
    .iREQ_WDATA (iREQ_WDATA),
    .oRSP_VALID (oRSP_VALID),
    .iRSP_READY (iRSP_READY),
    .oRSP_RDATA (oRSP_RDATA),
    .oRSP_ERR   (oRSP_ERR)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request after a falling edge; count rising edges until the response shows.
  task automatic present(input logic amo, input logic we, input logic [4:0] f5,
                         input logic [31:0] addr, input logic [31:0] wd, input logic rsp_rdy);
    @(negedge iCLK);
    iREQ_VALID = 1'b1;
    iREQ_AMO   = amo;
    iREQ_WE    = we;
    iREQ_FUNC5 = f5;
    iREQ_ADDR  = addr;
    iREQ_WDATA = wd;
    iRSP_READY = rsp_rdy;
    r_lat      = 0;
    do begin
      @(posedge iCLK);
      r_lat++;
      @(negedge iCLK);
      iREQ_VALID = 1'b0;
    end while (!oRSP_VALID && r_lat < 20);
    if (!oRSP_VALID) check("rsp_timeout", 32'd0, 32'd1);
    r_data = oRSP_RDATA;
    r_err  = oRSP_ERR;
  endtask

  task automatic op(input logic amo, input logic we, input logic [4:0] f5,
                    input logic [31:0] addr, input logic [31:0] wd);
    present(amo, we, f5, addr, wd, 1'b1);
    @(posedge iCLK);
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] d);
    op(1'b0, 1'b1, 5'h00, addr, d);
  endtask

  task automatic ld(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    op(1'b0, 1'b0, 5'h00, addr, 32'd0);
    check(tag, r_data, exp);
  endtask

  task automatic amo(input logic [4:0] f5, input logic [31:0] addr, input logic [31:0] src);
    op(1'b1, 1'b0, f5, addr, src);
  endtask

  initial begin
    iRST       = 1'b1;
    iREQ_VALID = 1'b0;
    iREQ_AMO   = 1'b0;
    iREQ_WE    = 1'b0;
    iREQ_FUNC5 = 5'h00;
    iREQ_ADDR  = 32'd0;
    iREQ_WDATA = 32'd0;
    iRSP_READY = 1'b1;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    check("rst_req_ready", {31'd0, oREQ_READY}, 32'd1);
    check("rst_rsp_valid", {31'd0, oRSP_VALID}, 32'd0);
    check("rst_rdata", oRSP_RDATA, 32'd0);
    check("rst_err", {31'd0, oRSP_ERR}, 32'd0);
    iRST = 1'b0;

    // Store, AMOADD with latency, load-back
    st(32'h40, 32'h0000_0010);
    check("st_rdata", r_data, 32'd0);
    check("st_err", {31'd0, r_err}, 32'd0);
    amo(5'h00, 32'h40, 32'h5);
    check("add_rdata", r_data, 32'h10);
    check("add_err", {31'd0, r_err}, 32'd0);
    check("add_latency", r_lat, 32'd3);
    ld("add_mem", 32'h40, 32'h15);

    // LR/SC success, then repeated SC fails
    st(32'h80, 32'hAAAA_5555);
    amo(5'h02, 32'h80, 32'd0);
    check("lr_rdata", r_data, 32'hAAAA_5555);
    amo(5'h03, 32'h80, 32'h1234_5678);
    check("sc_ok", r_data, 32'd0);
    ld("sc_ok_mem", 32'h80, 32'h1234_5678);
    amo(5'h03, 32'h80, 32'hDEAD_0000);
    check("sc_again", r_data, 32'd1);
    ld("sc_again_mem", 32'h80, 32'h1234_5678);

    // Store to the reserved word kills the reservation; neighbour store does not
    amo(5'h02, 32'h80, 32'd0);
    st(32'h80, 32'h11);
    amo(5'h03, 32'h80, 32'h22);
    check("sc_after_st", r_data, 32'd1);
    ld("sc_after_st_mem", 32'h80, 32'h11);
    amo(5'h02, 32'h80, 32'd0);
    st(32'h84, 32'h33);
    amo(5'h03, 32'h80, 32'h44);
    check("sc_after_nbr", r_data, 32'd0);
    ld("sc_after_nbr_mem", 32'h80, 32'h44);

    // Signed vs unsigned min/max at 0xFFFFFFFF
    st(32'h10, 32'hFFFF_FFFF);
    amo(5'h10, 32'h10, 32'd1);
    ld("amomin_mem", 32'h10, 32'hFFFF_FFFF);
    amo(5'h1C, 32'h10, 32'd1);
    ld("amomaxu_mem", 32'h10, 32'hFFFF_FFFF);
    amo(5'h18, 32'h10, 32'd1);
    check("amominu_rdata", r_data, 32'hFFFF_FFFF);
    ld("amominu_mem", 32'h10, 32'h1);

    // Logic ops, signed max, swap
    st(32'h20, 32'h0000_0F0F);
    amo(5'h04, 32'h20, 32'h0000_00FF);
    check("xor_rdata", r_data, 32'h0000_0F0F);
    amo(5'h08, 32'h20, 32'hF000_0000);
    check("or_rdata", r_data, 32'h0000_0FF0);
    amo(5'h0C, 32'h20, 32'hF000_00F0);
    check("and_rdata", r_data, 32'hF000_0FF0);
    amo(5'h14, 32'h20, 32'd1);
    check("max_rdata", r_data, 32'hF000_00F0);
    amo(5'h01, 32'h20, 32'hDEAD_BEEF);
    check("swap_rdata", r_data, 32'd1);
    ld("swap_mem", 32'h20, 32'hDEAD_BEEF);

    // Errors: misaligned and illegal func5; misaligned op leaves reservation alone
    amo(5'h01, 32'h42, 32'h99);
    check("mis_err", {31'd0, r_err}, 32'd1);
    check("mis_rdata", r_data, 32'd0);
    ld("mis_mem", 32'h40, 32'h15);
    amo(5'h1F, 32'h40, 32'h99);
    check("f5_err", {31'd0, r_err}, 32'd1);
    check("f5_rdata", r_data, 32'd0);
    ld("f5_mem", 32'h40, 32'h15);
    amo(5'h02, 32'h80, 32'd0);
    amo(5'h01, 32'h82, 32'h77);
    amo(5'h03, 32'h80, 32'h55);
    check("mis_keeps_res", r_data, 32'd0);

    // Address 0x400 wraps onto word 0
    st(32'h400, 32'hCAFE_F00D);
    ld("alias_word0", 32'h0, 32'hCAFE_F00D);

    // Response back-pressure
    present(1'b0, 1'b0, 5'h00, 32'h40, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge iCLK);
      @(negedge iCLK);
      check("hold_valid", {31'd0, oRSP_VALID}, 32'd1);
      check("hold_rdata", oRSP_RDATA, 32'h15);
      check("hold_req_ready", {31'd0, oREQ_READY}, 32'd0);
    end
    iRSP_READY = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    check("release_valid", {31'd0, oRSP_VALID}, 32'd0);
    check("release_ready", {31'd0, oREQ_READY}, 32'd1);

    // Reset while an AMOADD sits in READ
    amo(5'h1F, 32'h40, 32'd0);
    @(negedge iCLK);
    iREQ_VALID = 1'b1;
    iREQ_AMO   = 1'b1;
    iREQ_WE    = 1'b0;
    iREQ_FUNC5 = 5'h00;
    iREQ_ADDR  = 32'h40;
    iREQ_WDATA = 32'h100;
    @(posedge iCLK);
    @(negedge iCLK);
    iREQ_VALID = 1'b0;
    iRST       = 1'b1;
    #1;
    check("midrst_valid", {31'd0, oRSP_VALID}, 32'd0);
    check("midrst_rdata", oRSP_RDATA, 32'd0);
    check("midrst_err", {31'd0, oRSP_ERR}, 32'd0);
    check("midrst_ready", {31'd0, oREQ_READY}, 32'd1);
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    ld("midrst_mem", 32'h40, 32'h15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
